// File: rtl/bt_pkg.sv
// rtl/bt_pkg.sv - shared types and constants for the Bluetooth command receiver
package bt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;

  localparam int RX_FIFO_DEPTH = 4;

  // Bit times of continuous idle-high line needed after reset before a
  // falling edge is trusted as a start bit; longer than any high run inside
  // a frame, so a frame cut by reset cannot be mistaken for a new one.
  localparam int IDLE_BITS = 10;

endpackage

// File: rtl/bt_rx_fifo.sv
// rtl/bt_rx_fifo.sv - 4-entry received-byte FIFO (built only with BT_RX_FIFO_EN)
module bt_rx_fifo
  import bt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  input  logic       rd_en_i,
  output logic       empty_o,
  output logic       full_o,
  output logic [7:0] head_o
);

  localparam int PTR_W = $clog2(RX_FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(RX_FIFO_DEPTH);

  logic [7:0]       mem_q [RX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push;
  logic             pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign head_o  = mem_q[rd_ptr_q];
  assign pop     = rd_en_i && !empty_o;
  // A write into a full FIFO only lands if a pop frees a slot in the same cycle.
  assign push    = wr_en_i && (!full_o || pop);

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RX_FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bt_cmd_rcv.sv
// rtl/bt_cmd_rcv.sv - 8N1 serial byte receiver; BT_RX_FIFO_EN selects 4-entry FIFO over single buffer
module bt_cmd_rcv
  import bt_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic       rdy,
  output logic [7:0] rx_data,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam logic [11:0] DIV_FULL = 12'(BAUD_DIV);
  localparam logic [11:0] DIV_HALF = 12'(BAUD_DIV / 2);
  localparam logic [3:0]  ARM_LAST = 4'(IDLE_BITS - 1);

  logic       rx_m_q, rx_s_q, rx_p_q;
  rx_state_e  state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       armed_q, armed_d;
  logic       commit_q, commit_d;
  logic       frm_q, frm_d;
  logic       ovr_q;
  logic       expire;
  logic       fall;

  assign expire  = (cnt_q <= 12'd1);
  assign fall    = rx_p_q && !rx_s_q;
  assign frm_err = frm_q;
  assign ovr_err = ovr_q;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_p_q <= 1'b1;
    end else begin
      rx_m_q <= RX;
      rx_s_q <= rx_m_q;
      rx_p_q <= rx_s_q;
    end
  end

  // Frame FSM: start-bit qualification, mid-bit data sampling, stop check.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    armed_d  = armed_q;
    commit_d = 1'b0;
    frm_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!armed_q) begin
          // Not yet trusted after reset: count bit times of steady high line.
          if (!rx_s_q) begin
            cnt_d = DIV_FULL;
            bit_d = 4'd0;
          end else if (expire) begin
            cnt_d = DIV_FULL;
            if (bit_q == ARM_LAST) begin
              armed_d = 1'b1;
              bit_d   = 4'd0;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q - 12'd1;
          end
        end else if (fall) begin
          state_d = ST_START;
          cnt_d   = DIV_HALF;
        end
      end
      ST_START: begin
        if (expire) begin
          if (!rx_s_q) begin
            state_d = ST_DATA;
            cnt_d   = DIV_FULL;
            bit_d   = 4'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      ST_DATA: begin
        if (expire) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = DIV_FULL;
          if (bit_q == 4'd7) begin
            state_d = ST_STOP;
            bit_d   = 4'd0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      ST_STOP: begin
        if (expire) begin
          state_d = ST_IDLE;
          if (rx_s_q) commit_d = 1'b1;
          else        frm_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, counters and shift register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 12'd0;
      bit_q    <= 4'd0;
      shift_q  <= 8'h00;
      armed_q  <= 1'b0;
      commit_q <= 1'b0;
      frm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      armed_q  <= armed_d;
      commit_q <= commit_d;
      frm_q    <= frm_d;
    end
  end

`ifdef BT_RX_FIFO_EN
  logic fifo_empty;
  logic fifo_full;

  bt_rx_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (commit_q),
    .wr_data_i (shift_q),
    .rd_en_i   (clr_rdy),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .head_o    (rx_data)
  );

  assign rdy = !fifo_empty;

  // Overrun: byte arrives with the FIFO full and no pop to make room.
  always_ff @(posedge clk) begin
    if (rst) ovr_q <= 1'b0;
    else     ovr_q <= commit_q && fifo_full && !clr_rdy;
  end
`else
  logic       rdy_q;
  logic [7:0] data_q;

  assign rdy     = rdy_q;
  assign rx_data = data_q;

  // Single holding register: a new byte always wins over an acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q  <= 1'b0;
      data_q <= 8'h00;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (commit_q) begin
        data_q <= shift_q;
        rdy_q  <= 1'b1;
        ovr_q  <= rdy_q && !clr_rdy;
      end else if (clr_rdy) begin
        rdy_q <= 1'b0;
      end
    end
  end
`endif

endmodule
